// File: rtl/mult_seq_mac.sv
// mult_seq_mac: multi-cycle signed fixed-point multiplier / multiply-accumulate.
//
// Each WIDTH-bit operand is split into N = WIDTH/DIGIT digits. One signed
// (DIGIT+1)x(DIGIT+1) partial product is added into a 2*WIDTH-bit accumulator
// per cycle, for N*N cycles. The A-digit index is the inner loop. The exact
// product is then shifted right arithmetically by QUANT bits. In accumulate
// mode it is added to the previously delivered result before being registered.
//
// Optional build macro: MULT_SEQ_SATURATE_EN clamps the result to the signed
// WIDTH-bit range. Without it the result wraps to the low WIDTH bits.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands (IDLE)
//   a_i, b_i     signed operands
//   acc_i        accumulate mode, sampled with the operands
//   out_valid_o  result valid (DONE)
//   out_ready_i  consumer accepts result
//   p_o          signed quantised result
//   busy_o       high while in BUSY
module mult_seq_mac #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 8,
    parameter int unsigned QUANT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             acc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] p_o,
    output logic             busy_o
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned PW = 2 * DIGIT + 2;
    localparam int unsigned XW = (PW > AW) ? PW : AW;
    localparam int unsigned RW = AW + 1;
    localparam logic [CW-1:0] LastIdx = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
    logic             mode_q, mode_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    i_q, i_d, j_q, j_d;

    logic [DIGIT-1:0]        a_dig, b_dig;
    logic signed [DIGIT:0]   a_ext, b_ext;
    logic signed [PW-1:0]    pp;
    logic signed [XW-1:0]    pp_x;
    logic [31:0]             shamt;
    logic [AW-1:0]           pp_sh, acc_sum;
    logic signed [AW-1:0]    q;
    logic signed [RW-1:0]    r;
    logic [WIDTH-1:0]        p_res;

    // Partial product for digit pair (i, j). Only the top digit carries the sign.
    always_comb begin
        a_dig   = DIGIT'(a_q >> (32'(i_q) * DIGIT));
        b_dig   = DIGIT'(b_q >> (32'(j_q) * DIGIT));
        a_ext   = {(i_q == LastIdx) & a_dig[DIGIT-1], a_dig};
        b_ext   = {(j_q == LastIdx) & b_dig[DIGIT-1], b_dig};
        pp      = PW'(a_ext) * PW'(b_ext);
        pp_x    = XW'(pp);
        shamt   = (32'(i_q) + 32'(j_q)) * DIGIT;
        pp_sh   = AW'(pp_x << shamt);
        acc_sum = acc_q + pp_sh;
        q       = $signed(acc_sum) >>> QUANT;
        r       = RW'(q) + (mode_q ? RW'($signed(p_q)) : '0);
    end

`ifdef MULT_SEQ_SATURATE_EN
    localparam logic signed [RW-1:0] RMax = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] RMin = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    always_comb begin
        if (r > RMax) begin
            p_res = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (r < RMin) begin
            p_res = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            p_res = WIDTH'(r);
        end
    end
`else
    always_comb begin
        p_res = WIDTH'(r);
    end
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        i_d         = i_q;
        j_d         = j_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    mode_d  = acc_i;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                busy_o = 1'b1;
                acc_d  = acc_sum;
                if (i_q == LastIdx) begin
                    i_d = '0;
                    j_d = j_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
                if ((i_q == LastIdx) && (j_q == LastIdx)) begin
                    p_d     = p_res;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign p_o = p_q;

endmodule
